// File: rtl/ras_stack.sv
// ras_stack: speculative return address stack for the D1 decode stage.
// A DEPTH-entry circular stack. Calls push, returns pop, and a resteer
// restores the checkpointed pointer and count. Pointer arithmetic wraps
// modulo DEPTH, so a push onto a full stack overwrites the oldest entry.
//
// Optional feature macro: RAS_REPAIR_EN
//   Defined  : adds recover_addr / recover_top_valid. A recover with
//              recover_top_valid=1 also rewrites entry[recover_ptr], which
//              repairs a top entry clobbered by a wrong-path push.
//   Undefined: recover restores the pointers only.
module ras_stack #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 8,            // power of two, >= 2
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,            // asynchronous, active-low
    input  logic             push,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop,
    input  logic             recover,
    input  logic [PTR_W-1:0] recover_ptr,
    input  logic [PTR_W:0]   recover_count,
`ifdef RAS_REPAIR_EN
    input  logic [XLEN-1:0]  recover_addr,
    input  logic             recover_top_valid,
`endif
    output logic [XLEN-1:0]  ret_addr,
    output logic             ret_valid,
    output logic [PTR_W-1:0] tos_ptr,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q,   tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    // Single write port into the entry array, chosen by the next-state logic.
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [XLEN-1:0]  wr_data;

    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             is_empty;
    logic             is_full;

    // Neighbouring pointers; DEPTH is a power of two, so truncation wraps.
    always_comb begin
        ptr_inc  = tos_q + 1'b1;
        ptr_dec  = tos_q - 1'b1;
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_COUNT);
    end

    // Next-state: recover > push&pop > push > pop.
    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise a
        // path that skips an assignment infers a latch.
        tos_d   = tos_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_ptr  = tos_q;
        wr_data = push_addr;

        if (recover) begin
            tos_d   = recover_ptr;
            count_d = (recover_count > FULL_COUNT) ? FULL_COUNT : recover_count;
`ifdef RAS_REPAIR_EN
            if (recover_top_valid) begin
                wr_en   = 1'b1;
                wr_ptr  = recover_ptr;
                wr_data = recover_addr;
            end
`endif
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (is_empty) begin
                // Nothing to pop: behaves as a plain push.
                tos_d   = ptr_inc;
                wr_ptr  = ptr_inc;
                count_d = count_q + 1'b1;
            end else begin
                // Pop-then-push replaces the top entry in place.
                wr_ptr = tos_q;
            end
        end else if (push) begin
            wr_en  = 1'b1;
            tos_d  = ptr_inc;
            wr_ptr = ptr_inc;
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                tos_d   = ptr_dec;
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer, count and event-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            tos_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry array with its single write port.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the entries are reset on purpose: ret_addr is visible
        // unqualified and must read as zero after reset, not as stale data.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // Outputs: zero-latency top-of-stack read and status flags.
    always_comb begin
        ret_addr  = mem_q[tos_q];
        ret_valid = !is_empty;
        tos_ptr   = tos_q;
        count     = count_q;
        empty     = is_empty;
        full      = is_full;
        overflow  = ovf_q;
        underflow = unf_q;
    end

endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: scoreboard bench for ras_stack (XLEN=32, DEPTH=8).
// The driver pushes the expected post-edge state for every cycle it drives;
// a monitor pops and compares once that cycle's edge has passed.
// Build with +define+RAS_REPAIR_EN to exercise the repair ports.
module tb_ras_stack;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic [XLEN-1:0]  push_addr = '0;
    logic             pop = 1'b0;
    logic             recover = 1'b0;
    logic [PTR_W-1:0] recover_ptr = '0;
    logic [PTR_W:0]   recover_count = '0;
`ifdef RAS_REPAIR_EN
    logic [XLEN-1:0]  recover_addr = '0;
    logic             recover_top_valid = 1'b0;
`endif
    logic [XLEN-1:0]  ret_addr;
    logic             ret_valid;
    logic [PTR_W-1:0] tos_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    ras_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_addr     (push_addr),
        .pop           (pop),
        .recover       (recover),
        .recover_ptr   (recover_ptr),
        .recover_count (recover_count),
`ifdef RAS_REPAIR_EN
        .recover_addr      (recover_addr),
        .recover_top_valid (recover_top_valid),
`endif
        .ret_addr      (ret_addr),
        .ret_valid     (ret_valid),
        .tos_ptr       (tos_ptr),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [XLEN-1:0]  addr;
        logic [PTR_W-1:0] tos;
        logic [PTR_W:0]   cnt;
        logic             ovf;
        logic             unf;
        int               due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input exp_t e);
        check({e.name, ".ret_addr"},  64'(ret_addr),  64'(e.addr));
        check({e.name, ".ret_valid"}, 64'(ret_valid), 64'(e.cnt != 0));
        check({e.name, ".tos_ptr"},   64'(tos_ptr),   64'(e.tos));
        check({e.name, ".count"},     64'(count),     64'(e.cnt));
        check({e.name, ".empty"},     64'(empty),     64'(e.cnt == 0));
        check({e.name, ".full"},      64'(full),      64'(e.cnt == DEPTH));
        check({e.name, ".overflow"},  64'(overflow),  64'(e.ovf));
        check({e.name, ".underflow"}, 64'(underflow), 64'(e.unf));
    endtask

    // Monitor: compares each expectation once its clock edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                compare_all(e);
            end
        end
    end

    task automatic expect_state(input string nm, input logic [XLEN-1:0] ea,
                                input logic [PTR_W-1:0] et, input logic [PTR_W:0] ec,
                                input logic eo, input logic eu);
        exp_t e;
        e.name = nm; e.addr = ea; e.tos = et; e.cnt = ec;
        e.ovf = eo; e.unf = eu; e.due = cyc + 1;
        sb_q.push_back(e);
    endtask

    // One push/pop cycle plus the state expected after its edge.
    task automatic op(input logic pu, input logic po, input logic [XLEN-1:0] a,
                      input string nm, input logic [XLEN-1:0] ea,
                      input logic [PTR_W-1:0] et, input logic [PTR_W:0] ec,
                      input logic eo, input logic eu);
        @(negedge clk);
        push = pu; pop = po; push_addr = a; recover = 1'b0;
`ifdef RAS_REPAIR_EN
        recover_top_valid = 1'b0;
`endif
        expect_state(nm, ea, et, ec, eo, eu);
    endtask

    // Recover cycle with a wrong-path push asserted alongside it.
    task automatic rcv(input logic [PTR_W-1:0] rp, input logic [PTR_W:0] rc,
                       input logic [XLEN-1:0] fix_addr, input logic fix_valid,
                       input string nm, input logic [XLEN-1:0] ea,
                       input logic [PTR_W-1:0] et, input logic [PTR_W:0] ec);
        @(negedge clk);
        push = 1'b1; pop = 1'b0; push_addr = 32'hFF;
        recover = 1'b1; recover_ptr = rp; recover_count = rc;
`ifdef RAS_REPAIR_EN
        recover_addr = fix_addr; recover_top_valid = fix_valid;
`else
        if (fix_valid && fix_addr == '0) begin end
`endif
        expect_state(nm, ea, et, ec, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0; push = 1'b0; pop = 1'b0; recover = 1'b0;
        expect_state(nm, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        // ---------------- basic push / pop ----------------
        do_reset("reset");
        op(1, 0, 32'h1000, "push1", 32'h1000, 1, 1, 0, 0);
        op(1, 0, 32'h2000, "push2", 32'h2000, 2, 2, 0, 0);
        op(1, 0, 32'h3000, "push3", 32'h3000, 3, 3, 0, 0);
        op(0, 1, 0,        "pop1",  32'h2000, 2, 2, 0, 0);
        op(0, 1, 0,        "pop2",  32'h1000, 1, 1, 0, 0);
        op(0, 1, 0,        "pop3",  32'h0,    0, 0, 0, 0);

        // ---------------- overflow and wrap ----------------
        for (int k = 1; k <= 9; k++) begin
            op(1, 0, 32'(k * 'h100), $sformatf("ovf_push%0d", k), 32'(k * 'h100),
               3'(k % 8), (k >= 8) ? 4'd8 : 4'(k), (k == 9), 0);
        end
        op(0, 0, 0, "ovf_idle", 32'h900, 1, 8, 0, 0);
        // Tops seen after each pop: 0x800 down to 0x200, then stale 0x900.
        for (int k = 1; k <= 8; k++) begin
            op(0, 1, 0, $sformatf("ovf_pop%0d", k), (k == 8) ? 32'h900 : 32'((9 - k) * 'h100),
               3'((9 - k) % 8), 4'(8 - k), 0, 0);
        end

        // ---------------- underflow ----------------
        do_reset("reset2");
        op(0, 1, 0, "unf_pop",  32'h0, 0, 0, 0, 1);
        op(0, 0, 0, "unf_idle", 32'h0, 0, 0, 0, 0);
        op(1, 1, 32'h55, "pp_empty", 32'h55, 1, 1, 0, 0);
        op(0, 1, 0, "pp_empty_pop", 32'h0, 0, 0, 0, 0);

        // ---------------- push & pop together ----------------
        op(1, 0, 32'hA0, "pushA0", 32'hA0, 1, 1, 0, 0);
        op(1, 0, 32'hB0, "pushB0", 32'hB0, 2, 2, 0, 0);
        op(1, 1, 32'hC0, "ppC0",   32'hC0, 2, 2, 0, 0);
        op(0, 1, 0,      "popA0",  32'hA0, 1, 1, 0, 0);

        // ---------------- checkpoint recovery ----------------
        op(1, 0, 32'hC0, "pushC0", 32'hC0, 2, 2, 0, 0);   // checkpoint: tos=2 count=2
        op(1, 0, 32'hD0, "wp_pushD0", 32'hD0, 3, 3, 0, 0);
        op(0, 1, 0,      "wp_pop1",   32'hC0, 2, 2, 0, 0);
        op(0, 1, 0,      "wp_pop2",   32'hA0, 1, 1, 0, 0);
`ifdef RAS_REPAIR_EN
        rcv(2, 5'(2), 32'hEE, 1'b1, "recover_repair", 32'hEE, 2, 2);
`else
        rcv(2, 5'(2), 32'hEE, 1'b1, "recover", 32'hC0, 2, 2);
`endif
        // Oversized checkpoint count saturates; entry 3 still holds 0xD0.
        rcv(3, 4'd15, 32'h0, 1'b0, "recover_sat", 32'hD0, 3, 8);
        op(1, 1, 32'h77, "pp_full", 32'h77, 3, 8, 0, 0);
        op(0, 0, 0,      "pp_full_idle", 32'h77, 3, 8, 0, 0);

        // ---------------- asynchronous reset mid-operation ----------------
        do_reset("reset3");
        for (int k = 1; k <= 5; k++) begin
            op(1, 0, 32'(k * 'h11), $sformatf("pre_rst_push%0d", k), 32'(k * 'h11), 3'(k), 4'(k), 0, 0);
        end
        op(0, 0, 0, "pre_rst_idle", 32'h55, 5, 5, 0, 0);
        drain();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst.count",     64'(count),     64'd0);
        check("async_rst.ret_valid", 64'(ret_valid), 64'd0);
        check("async_rst.ret_addr",  64'(ret_addr),  64'd0);
        check("async_rst.tos_ptr",   64'(tos_ptr),   64'd0);
        check("async_rst.empty",     64'(empty),     64'd1);
        @(negedge clk);
        rst = 1'b1;
        op(1, 0, 32'h99, "post_rst_push", 32'h99, 1, 1, 0, 0);
        op(0, 0, 0,      "post_rst_idle", 32'h99, 1, 1, 0, 0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
